// File: rtl/div_seq_pkg.sv
// div_seq_pkg
// Shared definitions for the sequential divider: operand width, the RV32M
// divide opcode encodings, the FSM state type and small opcode decode helpers.
package div_seq_pkg;

  localparam int DIV_WIDTH = 32;

  // op[1] selects remainder, op[0] selects unsigned
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub
// Combinational trial subtractor a - b. Kept as its own module so the
// subtract can be retargeted to a DSP subtractor or the fabric carry chain
// without touching the divider FSM.
//   a, b   : W-bit operands
//   diff   : W-bit difference (modulo 2^W)
//   borrow : 1 when a < b (unsigned)
module div_trial_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] full;

  assign full   = {1'b0, a} - {1'b0, b};
  assign diff   = full[W-1:0];
  assign borrow = full[W];

endmodule

// File: rtl/div_seq.sv
// div_seq
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit
// per cycle, start/done handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, op           : request and opcode (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   dividend, divisor   : rs1 / rs2, sampled when start is accepted
//   flush               : synchronous abort of an in-flight operation
//   busy                : operation in flight
//   done                : one-cycle pulse, result valid
//   result              : quotient or remainder, held until the next done
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   r_q, r_d;        // partial remainder
  logic [WIDTH-1:0]   q_q, q_d;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;  // divisor magnitude
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               qsign_q, qsign_d;
  logic               rsign_q, rsign_d;
  logic               rem_sel_q, rem_sel_d;
  logic               done_q, done_d;

  // Operand conditioning at start
  logic               a_neg, b_neg, div_zero, ovf;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign a_neg    = op_is_signed(op) & dividend[WIDTH-1];
  assign b_neg    = op_is_signed(op) & divisor[WIDTH-1];
  assign a_mag    = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag    = b_neg ? (~divisor + 1'b1) : divisor;
  assign div_zero = (divisor == '0);
  assign ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
                    (dividend == MIN_NEG) && (divisor == '1);

  // Trial subtract of the shifted partial remainder. The remainder is always
  // below the divisor between iterations, so its 33rd bit is structurally zero
  // and only WIDTH bits are stored; likewise a non-borrowing difference never
  // sets its MSB.
  logic [WIDTH:0]     trial_a, trial_b, trial_diff;
  logic               trial_borrow;
  logic               unused_diff_msb;

  assign trial_a = {r_q, q_q[WIDTH-1]};
  assign trial_b = {1'b0, dvsr_q};
  assign unused_diff_msb = trial_diff[WIDTH];

  div_trial_sub #(.W(WIDTH + 1)) u_trial_sub (
    .a      (trial_a),
    .b      (trial_b),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // Sign fix-up applied in FIX
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign quot_fix = qsign_q ? (~q_q + 1'b1) : q_q;
  assign rem_fix  = rsign_q ? (~r_q + 1'b1) : r_q;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    q_d       = q_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    rem_sel_d = rem_sel_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // flush in the same cycle drops the request
        if (start && !flush) begin
          rem_sel_d = op_is_rem(op);
          cnt_d     = '0;
          if (div_zero) begin
            // quotient all ones, remainder is the raw dividend; no sign fix
            q_d     = '1;
            r_d     = dividend;
            qsign_d = 1'b0;
            rsign_d = 1'b0;
            state_d = ST_FIX;
          end else if (ovf) begin
            q_d     = MIN_NEG;
            r_d     = '0;
            qsign_d = 1'b0;
            rsign_d = 1'b0;
            state_d = ST_FIX;
          end else begin
            q_d     = a_mag;
            r_d     = '0;
            dvsr_d  = b_mag;
            qsign_d = a_neg ^ b_neg;
            rsign_d = a_neg;
            state_d = ST_ITER;
          end
        end
      end

      ST_ITER: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          // restore on borrow: keep the shifted remainder
          r_d   = trial_borrow ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], ~trial_borrow};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          result_d = rem_sel_q ? rem_fix : quot_fix;
          done_d   = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      r_q       <= '0;
      q_q       <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      q_q       <= q_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      qsign_q   <= qsign_d;
      rsign_q   <= rsign_d;
      rem_sel_q <= rem_sel_d;
      done_q    <= done_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq
// Self-checking bench for div_seq. Expected results and latencies are pushed
// to a scoreboard queue when a request is issued and popped when done fires.
module tb_div_seq;
  import div_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start at the next falling edge; returns 1ns after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit track, input logic [31:0] exp_res, input int lat,
                       input string nm);
    @(negedge clk);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (track) sb.push_back('{res: exp_res, lat: lat, name: nm});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count rising edges until done is seen (sampled 1ns after each edge).
  task automatic await_done(input int limit, output int edges, output bit got);
    edges = 0;
    got   = 1'b0;
    while (!got && edges < limit) begin
      @(posedge clk);
      #1;
      edges++;
      if (done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset: busy=%b done=%b result=%h", busy, done, result);
  endtask

  // Table-driven run of independent operations
  task automatic test_ops(input string tag, input int n, input logic [1:0] ops[8],
                          input logic [31:0] as[8], input logic [31:0] bs[8],
                          input logic [31:0] rs[8], input int lats[8]);
    int   edges;
    bit   got;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      issue(ops[i], as[i], bs[i], 1'b1, rs[i], lats[i], $sformatf("%s_%0d", tag, i));
      total++; if (busy !== 1'b1 && lats[i] > 1) begin bad++; $display("FAIL %s_%0d_busy: got %b want 1", tag, i, busy); end
      await_done(100, edges, got);
      e = sb.pop_front();
      total++;
      if (!got) begin
        bad++; $display("FAIL %s_timeout: no done within 100 edges", e.name);
      end else begin
        if (edges !== e.lat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", e.name, edges, e.lat); end
        total++;
        if (result !== e.res) begin bad++; $display("FAIL %s_result: got %h want %h", e.name, result, e.res); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_at_done: got %b want 0", e.name, busy); end
      end
      $display("txn %s: op=%b a=%h b=%h result=%h edges=%0d", e.name, ops[i], as[i], bs[i], result, edges);
      // done must be a single-cycle pulse
      @(posedge clk);
      #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse: got %b want 0", e.name, done); end
    end
  endtask

  task automatic test_unsigned();
    logic [1:0]  o[8] = '{OP_DIVU, OP_REMU, OP_DIVU, OP_DIVU, 2'b0, 2'b0, 2'b0, 2'b0};
    logic [31:0] a[8] = '{32'd100, 32'd100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0};
    logic [31:0] b[8] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'h0001_0000, 0, 0, 0, 0};
    logic [31:0] r[8] = '{32'd14, 32'd2, 32'd0, 32'h0000_FFFF, 0, 0, 0, 0};
    int          l[8] = '{33, 33, 33, 33, 0, 0, 0, 0};
    test_ops("unsigned", 4, o, a, b, r, l);
  endtask

  task automatic test_signed();
    logic [1:0]  o[8] = '{OP_DIV, OP_REM, OP_REM, OP_DIV, OP_DIV, 2'b0, 2'b0, 2'b0};
    logic [31:0] a[8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FF9C, 0, 0, 0};
    logic [31:0] b[8] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF6, 0, 0, 0};
    logic [31:0] r[8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD, 32'd10, 0, 0, 0};
    int          l[8] = '{33, 33, 33, 33, 33, 0, 0, 0};
    test_ops("signed", 5, o, a, b, r, l);
  endtask

  task automatic test_special();
    logic [1:0]  o[8] = '{OP_DIV, OP_REMU, OP_REM, OP_DIVU, OP_DIV, OP_REM, 2'b0, 2'b0};
    logic [31:0] a[8] = '{32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFF9, 32'd5,
                          32'h8000_0000, 32'h8000_0000, 0, 0};
    logic [31:0] b[8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0};
    logic [31:0] r[8] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                          32'h8000_0000, 32'd0, 0, 0};
    int          l[8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    test_ops("special", 6, o, a, b, r, l);
  endtask

  task automatic test_start_while_busy();
    int   edges;
    bit   got;
    exp_t e;
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 33, "busy_start");
    repeat (4) @(posedge clk);
    // second request lands on iteration 5 and must be ignored
    @(negedge clk);
    op = OP_DIV; dividend = 32'd5; divisor = 32'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    await_done(100, edges, got);
    e = sb.pop_front();
    total++;
    if (!got) begin
      bad++; $display("FAIL %s_timeout: no done within 100 edges", e.name);
    end else begin
      if (edges + 5 !== e.lat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", e.name, edges + 5, e.lat); end
      total++;
      if (result !== e.res) begin bad++; $display("FAIL %s_result: got %h want %h", e.name, result, e.res); end
    end
    $display("txn %s: result=%h edges=%0d", e.name, result, edges + 5);
    await_done(40, edges, got);
    total++; if (got) begin bad++; $display("FAIL busy_start_queued: got done=1 want no done"); end
  endtask

  task automatic test_flush();
    int   edges;
    bit   got;
    logic [31:0] held;
    held = result;
    issue(OP_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0, 0, "flush");
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done: got %b want 0", done); end
    await_done(40, edges, got);
    total++; if (got) begin bad++; $display("FAIL flush_late_done: got done=1 want no done"); end
    total++; if (result !== held) begin bad++; $display("FAIL flush_result: got %h want %h", result, held); end
    $display("txn flush: busy=%b result=%h", busy, result);
  endtask

  task automatic test_flush_start_idle();
    int edges;
    bit got;
    @(negedge clk);
    op = OP_DIVU; dividend = 32'd9; divisor = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy: got %b want 0", busy); end
    await_done(40, edges, got);
    total++; if (got) begin bad++; $display("FAIL flush_start_done: got done=1 want no done"); end
    $display("txn flush_start_idle: busy=%b", busy);
  endtask

  task automatic test_async_reset();
    int   edges;
    bit   got;
    exp_t e;
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd7, 1'b0, 32'd0, 0, "rst_mid");
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL async_rst_done: got %b want 0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL async_rst_result: got %h want 00000000", result); end
    $display("txn async_reset: busy=%b done=%b result=%h", busy, done, result);
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 33, "post_rst");
    await_done(100, edges, got);
    e = sb.pop_front();
    total++;
    if (!got) begin
      bad++; $display("FAIL %s_timeout: no done within 100 edges", e.name);
    end else begin
      if (edges !== e.lat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", e.name, edges, e.lat); end
      total++;
      if (result !== e.res) begin bad++; $display("FAIL %s_result: got %h want %h", e.name, result, e.res); end
    end
    $display("txn %s: result=%h edges=%0d", e.name, result, edges);
  endtask

  task automatic test_back_to_back();
    int   edges;
    bit   got;
    exp_t e;
    issue(OP_REMU, 32'd100, 32'd7, 1'b1, 32'd2, 33, "b2b_a");
    for (int k = 0; k < 2; k++) begin
      await_done(100, edges, got);
      e = sb.pop_front();
      total++;
      if (!got) begin
        bad++; $display("FAIL %s_timeout: no done within 100 edges", e.name);
      end else begin
        if (edges !== e.lat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", e.name, edges, e.lat); end
        total++;
        if (result !== e.res) begin bad++; $display("FAIL %s_result: got %h want %h", e.name, result, e.res); end
      end
      $display("txn %s: result=%h edges=%0d", e.name, result, edges);
      if (k == 0) begin
        // accepted on the edge that ends the done cycle
        issue(OP_DIV, 32'hFFFF_FC18, 32'd10, 1'b1, 32'hFFFF_FF9C, 33, "b2b_b");
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_cleared: got %b want 0", done); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_start_while_busy();
    test_flush();
    test_flush_start_idle();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
